apple_spawn_ctrl: RTL and testbench
===================================

# apple_spawn_ctrl

Sequencer that places a new apple after the snake eats one. On an accepted `eat` pulse it samples a candidate cell from the random-point generator, folds it into the playfield, checks it against the current apple and every snake segment via a one-cycle-latency segment read port, and retries on any collision. It sits between the snake body store and the apple/render logic and is the only writer of the apple position.

## Interface
- H_LOGIC_WIDTH, 5: x coordinate width
- V_LOGIC_WIDTH, 5: y coordinate width
- H_LOGIC_MAX, 31: largest legal x
- V_LOGIC_MAX, 23: largest legal y
- LEN_WIDTH, 10: width of `length` and `seg_addr`
- MAX_LEN, 201: segment-store depth; `length` is clamped to this
- MAX_RETRY, 15: rejections per burst before a fail pulse (≥1)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- eat  in  1  apple-eaten request, sampled in IDLE only
- length  in  LEN_WIDTH  current snake length in segments
- rand_x  in  H_LOGIC_WIDTH  random x from the random-point generator
- rand_y  in  V_LOGIC_WIDTH  random y from the random-point generator
- seg_rd  out  1  segment read strobe
- seg_addr  out  LEN_WIDTH  segment index (0 = head)
- seg_x  in  H_LOGIC_WIDTH  segment x, valid the cycle after `seg_rd`
- seg_y  in  V_LOGIC_WIDTH  segment y, valid the cycle after `seg_rd`
- appleX  out  H_LOGIC_WIDTH  committed apple x
- appleY  out  V_LOGIC_WIDTH  committed apple y
- apple_vld  out  1  apple on board
- busy  out  1  placement in progress
- spawn_done  out  1  one-cycle pulse on commit
- spawn_fail  out  1  one-cycle pulse on retry exhaustion

## Operation
- Reset (rst low, asynchronous): state IDLE, appleX=3, appleY=0, apple_vld=1, busy=0, seg_rd=0, seg_addr=0, spawn_done=0, spawn_fail=0, retry count=0.
- States: IDLE, SAMPLE, SCAN, COMMIT, FAIL. All outputs are registered.
- IDLE:
  - On `eat`=1, capture len_q = min(length, MAX_LEN) and go to SAMPLE.
  - busy=1 and apple_vld=0 from that edge.
  - `eat` in any other state is ignored and not queued.
- SAMPLE (1 cycle): register the candidate.
  - cand_x = rand_x > H_LOGIC_MAX ? rand_x − (H_LOGIC_MAX+1) : rand_x.
  - cand_y is formed the same way from rand_y and V_LOGIC_MAX.
  - Go to SCAN; if len_q=0, go straight to COMMIT (the apple-equality check still applies, see SCAN).
- SCAN:
  - The first SCAN cycle compares the candidate with the current appleX/appleY; a match is a rejection.
  - seg_rd=1 with seg_addr = 0, 1, … len_q−1, one per cycle.
  - The returned seg_x/seg_y is compared in the following cycle; a match is a rejection.
  - Reads still outstanding when a rejection occurs are discarded.
  - After the compare for index len_q−1 with no rejection, go to COMMIT.
- Rejection:
  - retry count increments.
  - If it reaches MAX_RETRY, go to FAIL; otherwise go to SAMPLE.
- COMMIT (1 cycle): the edge entering COMMIT loads appleX/appleY with the candidate and sets apple_vld=1. spawn_done=1 and busy=0 during COMMIT. Retry count clears. Then go to IDLE.
- FAIL (1 cycle): spawn_fail=1. Retry count clears, apple_vld stays 0, appleX/appleY are unchanged. Then go to SAMPLE automatically.
- len_q is frozen for the whole burst; later changes to `length` apply only to the next `eat`.

## Timing
- `eat` sampled at cycle 0: SAMPLE in cycle 1, first SCAN cycle in cycle 2.
- Clean spawn with L=len_q>0: reads at cycles 2..L+1, compares at cycles 3..L+2, COMMIT at cycle L+3.
- Clean spawn with L=0: COMMIT at cycle 2.
- Apple-equality rejection: detected in cycle 2, SAMPLE at cycle 3.
- Segment k collision: detected in cycle 3+k, SAMPLE at cycle 4+k.
- A candidate is never committed onto a segment with index < len_q, nor onto the previous apple.
- rst asserted mid-burst forces reset values immediately; no spawn_done is produced.

## Test plan
- Reset then idle: appleX=3, appleY=0, apple_vld=1, busy=0; all pulses stay 0 for 20 cycles.
- L=3, segments (5,5),(5,6),(5,7), rand=(10,4): COMMIT at cycle 6; appleX=10, appleY=4, spawn_done for 1 cycle; seg_addr 0,1,2 at cycles 2–4.
- rand_y=28, rand_x=31, L=0: apple=(31,4), committed at cycle 2.
- L=4, rand first (5,6) matching segment 1, then (9,9): rejection at cycle 4, SAMPLE at cycle 5, commit (9,9) at cycle 11; one retry counted.
- rand held at a segment cell, MAX_RETRY=15: spawn_fail pulses after the 15th rejection; apple_vld stays 0; appleX/appleY unchanged; sampling resumes.
- `eat` pulsed while busy is ignored, and `length` changed mid-burst is ignored (len_q holds). rst dropped during SCAN restores reset values asynchronously; exactly one spawn_done follows a subsequent clean `eat`.

Source files
------------

// File: rtl/apple_spawn_ctrl.sv
// apple_spawn_ctrl
// Places a new apple after the snake eats one. An accepted eat samples a
// candidate cell from the random-point generator, folds it into the playfield,
// and rejects it if it lands on the current apple or on any of the first len_q
// snake segments (read one per cycle through a one-cycle-latency port). Too
// many rejections in a row raise a fail pulse, and sampling then continues.
// This block is the only writer of the apple position.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   eat        apple-eaten request, accepted in IDLE only
//   length     current snake length (clamped to MAX_LEN on capture)
//   rand_x/y   random point from the generator
//   seg_rd     segment read strobe
//   seg_addr   segment index (0 = head)
//   seg_x/y    segment coordinate, valid the cycle after seg_rd
//   appleX/Y   committed apple position
//   apple_vld  apple on board
//   busy       placement in progress
//   spawn_done one-cycle pulse on commit
//   spawn_fail one-cycle pulse on retry exhaustion
module apple_spawn_ctrl #(
   parameter int H_LOGIC_WIDTH = 5,
   parameter int V_LOGIC_WIDTH = 5,
   parameter int H_LOGIC_MAX   = 31,
   parameter int V_LOGIC_MAX   = 23,
   parameter int LEN_WIDTH     = 10,
   parameter int MAX_LEN       = 201,
   parameter int MAX_RETRY     = 15
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     eat,
   input  logic [LEN_WIDTH-1:0]     length,
   input  logic [H_LOGIC_WIDTH-1:0] rand_x,
   input  logic [V_LOGIC_WIDTH-1:0] rand_y,
   output logic                     seg_rd,
   output logic [LEN_WIDTH-1:0]     seg_addr,
   input  logic [H_LOGIC_WIDTH-1:0] seg_x,
   input  logic [V_LOGIC_WIDTH-1:0] seg_y,
   output logic [H_LOGIC_WIDTH-1:0] appleX,
   output logic [V_LOGIC_WIDTH-1:0] appleY,
   output logic                     apple_vld,
   output logic                     busy,
   output logic                     spawn_done,
   output logic                     spawn_fail
);

   localparam int RETRY_W = $clog2(MAX_RETRY + 1);

   localparam logic [LEN_WIDTH-1:0]     MAX_LEN_C    = LEN_WIDTH'(MAX_LEN);
   localparam logic [LEN_WIDTH-1:0]     LEN_ONE      = LEN_WIDTH'(1);
   localparam logic [H_LOGIC_WIDTH:0]   H_MAX_C      = (H_LOGIC_WIDTH + 1)'(H_LOGIC_MAX);
   localparam logic [V_LOGIC_WIDTH:0]   V_MAX_C      = (V_LOGIC_WIDTH + 1)'(V_LOGIC_MAX);
   localparam logic [H_LOGIC_WIDTH-1:0] H_SPAN_C     = H_LOGIC_WIDTH'(H_LOGIC_MAX + 1);
   localparam logic [V_LOGIC_WIDTH-1:0] V_SPAN_C     = V_LOGIC_WIDTH'(V_LOGIC_MAX + 1);
   localparam logic [H_LOGIC_WIDTH-1:0] APPLE_X0     = H_LOGIC_WIDTH'(3);
   localparam logic [RETRY_W-1:0]       RETRY_LAST_C = RETRY_W'(MAX_RETRY - 1);
   localparam logic [RETRY_W-1:0]       RETRY_ONE    = RETRY_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SAMPLE,
      S_SCAN,
      S_COMMIT,
      S_FAIL
   } state_t;

   state_t                   r_state;
   logic [LEN_WIDTH-1:0]     r_len_q;
   logic [H_LOGIC_WIDTH-1:0] r_cand_x;
   logic [V_LOGIC_WIDTH-1:0] r_cand_y;
   logic [RETRY_W-1:0]       r_retry;
   logic                     r_first;    // first SCAN cycle: apple-equality check
   logic                     r_cmp_vld;  // seg_x/seg_y carry a requested segment

   logic [H_LOGIC_WIDTH-1:0] w_fold_x;
   logic [V_LOGIC_WIDTH-1:0] w_fold_y;
   logic                     w_fold_hit_apple;
   logic                     w_scan_hit;
   logic                     w_reject;
   logic                     w_commit;
   logic [H_LOGIC_WIDTH-1:0] w_commit_x;
   logic [V_LOGIC_WIDTH-1:0] w_commit_y;

   always_comb begin
      w_fold_x = ({1'b0, rand_x} > H_MAX_C) ? (rand_x - H_SPAN_C) : rand_x;
      w_fold_y = ({1'b0, rand_y} > V_MAX_C) ? (rand_y - V_SPAN_C) : rand_y;
      w_fold_hit_apple = (w_fold_x == appleX) && (w_fold_y == appleY);
      w_scan_hit = (r_first && (r_cand_x == appleX) && (r_cand_y == appleY)) ||
                   (r_cmp_vld && (seg_x == r_cand_x) && (seg_y == r_cand_y));
      w_reject   = 1'b0;
      w_commit   = 1'b0;
      w_commit_x = r_cand_x;
      w_commit_y = r_cand_y;
      case (r_state)
         // Zero-length snake: the apple check is done on the folded sample
         // directly so COMMIT follows SAMPLE with no SCAN cycle.
         S_SAMPLE: begin
            if (r_len_q == '0) begin
               if (w_fold_hit_apple) begin
                  w_reject = 1'b1;
               end else begin
                  w_commit   = 1'b1;
                  w_commit_x = w_fold_x;
                  w_commit_y = w_fold_y;
               end
            end
         end
         // Reads have stopped and the last returned segment is being
         // compared: a clean compare here completes the scan.
         S_SCAN: begin
            if (w_scan_hit) begin
               w_reject = 1'b1;
            end else if (r_cmp_vld && !seg_rd) begin
               w_commit = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_len_q    <= '0;
         r_cand_x   <= '0;
         r_cand_y   <= '0;
         r_retry    <= '0;
         r_first    <= 1'b0;
         r_cmp_vld  <= 1'b0;
         appleX     <= APPLE_X0;
         appleY     <= '0;
         apple_vld  <= 1'b1;
         busy       <= 1'b0;
         seg_rd     <= 1'b0;
         seg_addr   <= '0;
         spawn_done <= 1'b0;
         spawn_fail <= 1'b0;
      end else begin
         spawn_done <= 1'b0;
         spawn_fail <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (eat) begin
                  r_len_q   <= (length > MAX_LEN_C) ? MAX_LEN_C : length;
                  busy      <= 1'b1;
                  apple_vld <= 1'b0;
                  r_state   <= S_SAMPLE;
               end
            end
            S_SAMPLE: begin
               r_cand_x  <= w_fold_x;
               r_cand_y  <= w_fold_y;
               r_first   <= 1'b1;
               r_cmp_vld <= 1'b0;
               seg_addr  <= '0;
               if (r_len_q != '0) begin
                  seg_rd  <= 1'b1;
                  r_state <= S_SCAN;
               end
            end
            S_SCAN: begin
               r_first   <= 1'b0;
               r_cmp_vld <= seg_rd;
               if (seg_rd) begin
                  if (seg_addr == r_len_q - LEN_ONE) begin
                     seg_rd <= 1'b0;
                  end else begin
                     seg_addr <= seg_addr + LEN_ONE;
                  end
               end
            end
            S_COMMIT: r_state <= S_IDLE;
            S_FAIL:   r_state <= S_SAMPLE;
            default:  r_state <= S_IDLE;
         endcase

         // Outcome of the current compare overrides the per-state stepping
         // above; any reads still in flight are dropped.
         if (w_reject) begin
            seg_rd    <= 1'b0;
            seg_addr  <= '0;
            r_cmp_vld <= 1'b0;
            if (r_retry == RETRY_LAST_C) begin
               r_retry    <= '0;
               spawn_fail <= 1'b1;
               r_state    <= S_FAIL;
            end else begin
               r_retry <= r_retry + RETRY_ONE;
               r_state <= S_SAMPLE;
            end
         end else if (w_commit) begin
            appleX     <= w_commit_x;
            appleY     <= w_commit_y;
            apple_vld  <= 1'b1;
            busy       <= 1'b0;
            spawn_done <= 1'b1;
            seg_rd     <= 1'b0;
            seg_addr   <= '0;
            r_cmp_vld  <= 1'b0;
            r_retry    <= '0;
            r_state    <= S_COMMIT;
         end
      end
   end

endmodule

// File: tb/tb_apple_spawn_ctrl.sv
// Scoreboard bench for apple_spawn_ctrl. A timeline-level model predicts,
// for every burst, the cycle and kind of each spawn_done / spawn_fail pulse
// and the apple position, and queues it; a monitor pops on every pulse.
module tb_apple_spawn_ctrl;

   localparam int HW = 5, VW = 5, HMAX = 31, VMAX = 23;
   localparam int LW = 10, MAXL = 201, MAXR = 15;
   localparam int TMASK = 4095;
   localparam int WIN = 3000;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          eat = 1'b0;
   logic [LW-1:0] length = '0;
   logic [HW-1:0] rand_x = '0;
   logic [VW-1:0] rand_y = '0;
   logic          seg_rd;
   logic [LW-1:0] seg_addr;
   logic [HW-1:0] seg_x = '0;
   logic [VW-1:0] seg_y = '0;
   logic [HW-1:0] appleX;
   logic [VW-1:0] appleY;
   logic          apple_vld, busy, spawn_done, spawn_fail;

   apple_spawn_ctrl #(
      .H_LOGIC_WIDTH(HW), .V_LOGIC_WIDTH(VW), .H_LOGIC_MAX(HMAX), .V_LOGIC_MAX(VMAX),
      .LEN_WIDTH(LW), .MAX_LEN(MAXL), .MAX_RETRY(MAXR)
   ) dut (
      .clk(clk), .rst(rst), .eat(eat), .length(length), .rand_x(rand_x), .rand_y(rand_y),
      .seg_rd(seg_rd), .seg_addr(seg_addr), .seg_x(seg_x), .seg_y(seg_y),
      .appleX(appleX), .appleY(appleY), .apple_vld(apple_vld), .busy(busy),
      .spawn_done(spawn_done), .spawn_fail(spawn_fail)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // Per-cycle random-point table, segment store, model apple.
   int tab_x [0:TMASK];
   int tab_y [0:TMASK];
   int mem_x [0:MAXL-1];
   int mem_y [0:MAXL-1];
   int ax = 3, ay = 0;
   int cur_L = 0;

   typedef struct {
      int t;
      bit fail;
      int x;
      int y;
   } exp_t;
   exp_t sbq[$];

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic int fold(input int v, input int mx);
      return (v > mx) ? v - (mx + 1) : v;
   endfunction

   always @(negedge clk) begin
      rand_x = HW'(tab_x[cyc & TMASK]);
      rand_y = VW'(tab_y[cyc & TMASK]);
   end

   always @(posedge clk) begin
      if (seg_rd && seg_addr < LW'(MAXL)) begin
         seg_x <= HW'(mem_x[seg_addr]);
         seg_y <= VW'(mem_y[seg_addr]);
      end
   end

   // Pulse monitor / scoreboard consumer.
   always @(negedge clk) begin
      exp_t e;
      if (rst && (spawn_done || spawn_fail)) begin
         if (sbq.size() == 0) begin
            chk("unexpected_pulse", int'({spawn_done, spawn_fail}), 0);
         end else begin
            e = sbq.pop_front();
            chk("pulse_cycle", cyc, e.t);
            chk("spawn_done", int'(spawn_done), e.fail ? 0 : 1);
            chk("spawn_fail", int'(spawn_fail), e.fail ? 1 : 0);
            chk("appleX", int'(appleX), e.x);
            chk("appleY", int'(appleY), e.y);
            chk("apple_vld", int'(apple_vld), e.fail ? 0 : 1);
            chk("busy", int'(busy), e.fail ? 1 : 0);
         end
      end
   end

   // Read-port protocol: indices run 0,1,2.. within a scan and stay below len_q.
   bit            prev_rd = 1'b0;
   logic [LW-1:0] prev_addr = '0;
   always @(negedge clk) begin
      if (!rst) begin
         prev_rd = 1'b0;
      end else begin
         if (seg_rd) begin
            chk("seg_addr_seq", int'(seg_addr), prev_rd ? int'(prev_addr) + 1 : 0);
            chk("seg_addr_range", int'(int'(seg_addr) < cur_L), 1);
         end
         prev_rd   = seg_rd;
         prev_addr = seg_addr;
      end
   end

   task automatic finish_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   endtask

   // Timeline model: attempt starting in SAMPLE cycle s either commits after
   // scanning L segments, or is rejected by the apple (seen on the first scan
   // cycle) or by the lowest colliding segment k (seen once its read returns).
   task automatic model_burst(input int t_eat, input int L, output int t_end);
      int s, retries, cx, cy, nxt;
      bit done;
      s = t_eat + 1;
      retries = 0;
      done = 1'b0;
      t_end = s;
      while (!done) begin
         if (s > t_eat + WIN - 8) begin
            errors++;
            $display("FAIL model_window burst at %0d exceeds stimulus window", t_eat);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $fatal(1);
         end
         cx = fold(tab_x[s & TMASK], HMAX);
         cy = fold(tab_y[s & TMASK], VMAX);
         nxt = -1;
         if (cx == ax && cy == ay) begin
            nxt = (L == 0) ? s + 1 : s + 2;
         end else begin
            for (int i = 0; i < L; i++) begin
               if (nxt < 0 && mem_x[i] == cx && mem_y[i] == cy) nxt = s + 3 + i;
            end
         end
         if (nxt < 0) begin
            t_end = (L == 0) ? s + 1 : s + L + 2;
            ax = cx;
            ay = cy;
            sbq.push_back('{t: t_end, fail: 1'b0, x: cx, y: cy});
            done = 1'b1;
         end else begin
            retries++;
            if (retries == MAXR) begin
               sbq.push_back('{t: nxt, fail: 1'b1, x: ax, y: ay});
               retries = 0;
               s = nxt + 1;
            end else begin
               s = nxt;
            end
         end
      end
   endtask

   task automatic fill_const(input int from, input int n, input int x, input int y);
      for (int p = from; p < from + n; p++) begin
         tab_x[p & TMASK] = x;
         tab_y[p & TMASK] = y;
      end
   endtask

   task automatic fill_rand(input int from, input int n, input int L, input int pct_hit);
      int r, k;
      for (int p = from; p < from + n; p++) begin
         r = $urandom_range(0, 99);
         if (L > 0 && r < pct_hit) begin
            k = $urandom_range(0, L - 1);
            tab_x[p & TMASK] = mem_x[k];
            tab_y[p & TMASK] = (mem_y[k] < 8 && $urandom_range(0, 1) == 1) ? mem_y[k] + 24 : mem_y[k];
         end else if (r < pct_hit + 5) begin
            tab_x[p & TMASK] = ax;
            tab_y[p & TMASK] = ay;
         end else begin
            tab_x[p & TMASK] = $urandom_range(0, 31);
            tab_y[p & TMASK] = $urandom_range(0, 31);
         end
      end
   endtask

   task automatic rand_mem();
      for (int i = 0; i < MAXL; i++) begin
         mem_x[i] = $urandom_range(0, HMAX);
         mem_y[i] = $urandom_range(0, VMAX);
      end
   endtask

   // Called at a negedge with the table already filled for later cycles.
   task automatic burst(input int raw_len, input bit noisy);
      int t, L, t_end;
      t = cyc;
      L = (raw_len > MAXL) ? MAXL : raw_len;
      cur_L = L;
      length = LW'(raw_len);
      eat = 1'b1;
      model_burst(t, L, t_end);
      while (cyc < t_end) begin
         @(negedge clk);
         eat = noisy ? ($urandom_range(0, 3) == 0) : 1'b0;
         if (noisy && $urandom_range(0, 3) == 0) length = LW'($urandom_range(0, 300));
      end
      eat = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #900000;
      errors++;
      $display("FAIL watchdog simulation time limit reached at cycle %0d", cyc);
      finish_run();
   end

   initial begin
      int raw;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_appleX", int'(appleX), 3);
         chk("idle_appleY", int'(appleY), 0);
         chk("idle_vld", int'(apple_vld), 1);
         chk("idle_busy", int'(busy), 0);
         chk("idle_pulses", int'({spawn_done, spawn_fail, seg_rd}), 0);
      end

      // Three segments, clean candidate (10,4).
      mem_x[0] = 5; mem_y[0] = 5;
      mem_x[1] = 5; mem_y[1] = 6;
      mem_x[2] = 5; mem_y[2] = 7;
      mem_x[3] = 5; mem_y[3] = 8;
      fill_const(cyc + 1, WIN, 10, 4);
      burst(3, 1'b0);

      // Zero length, both coordinates folded/at the edge.
      fill_const(cyc + 1, WIN, 31, 28);
      burst(0, 1'b0);

      // First candidate hits segment 1, second is clean.
      fill_const(cyc + 1, WIN, 9, 9);
      tab_x[(cyc + 1) & TMASK] = 5;
      tab_y[(cyc + 1) & TMASK] = 6;
      burst(4, 1'b0);

      // Candidate pinned on the head until well past retry exhaustion.
      fill_const(cyc + 1, WIN, 20, 20);
      fill_const(cyc + 1, 70, 5, 5);
      burst(4, 1'b0);

      // Random short snakes; odd bursts also pulse eat and change length mid-burst.
      for (int b = 0; b < 30; b++) begin
         rand_mem();
         raw = $urandom_range(0, 12);
         fill_rand(cyc + 1, WIN, raw, 40);
         burst(raw, b[0]);
      end

      // Long snakes around the clamp.
      for (int b = 0; b < 3; b++) begin
         rand_mem();
         raw = (b == 0) ? 200 : (b == 1) ? 201 : 300;
         fill_rand(cyc + 1, WIN, (raw > MAXL) ? MAXL : raw, 8);
         burst(raw, 1'b1);
      end

      // Reset asserted during SCAN: immediate reset values, no pulse from that burst.
      rand_mem();
      fill_rand(cyc + 1, WIN, 5, 0);
      cur_L = 5;
      length = LW'(5);
      eat = 1'b1;
      @(negedge clk);
      eat = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("rst_appleX", int'(appleX), 3);
      chk("rst_appleY", int'(appleY), 0);
      chk("rst_vld", int'(apple_vld), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_seg", int'({seg_rd, seg_addr}), 0);
      chk("rst_pulses", int'({spawn_done, spawn_fail}), 0);
      ax = 3;
      ay = 0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      fill_rand(cyc + 1, WIN, 5, 0);
      burst(5, 1'b0);

      repeat (10) @(negedge clk);
      chk("scoreboard_drained", sbq.size(), 0);
      finish_run();
   end

endmodule
